// File: rtl/pool2x2_stream.sv
// pool2x2_stream
//   Streaming 2x2 / stride-2 signed max pooling over an FM_W x FM_H
//   feature map delivered in row-major raster order, one sample per
//   accepted cycle, with no backpressure.
//
//   Even rows fold each horizontal pair into a line buffer of FM_W/2
//   entries. Odd rows fold their horizontal pair against that entry and
//   emit the 2x2 max one clock after the bottom-right sample is accepted.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       async active-low reset (deassertion synchronised inside)
//   i_flush       sync frame restart; overrides same-cycle i_valid
//   i_valid       i_data holds a conv sample this cycle
//   i_data        signed sample, DW bits
//   o_valid       o_data holds a pooled result this cycle (1-cycle pulse)
//   o_data        signed 2x2 max; holds its value while o_valid=0
//   o_frame_done  pulse with the last pooled output of a frame

`ifndef DW
`define DW 16
`endif

module pool2x2_stream #(
    parameter int DW   = `DW,
    parameter int FM_W = 8,
    parameter int FM_H = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic signed [DW-1:0] i_data,
    output logic                 o_valid,
    output logic signed [DW-1:0] o_data,
    output logic                 o_frame_done
);

    localparam int CW = (FM_W > 2) ? $clog2(FM_W) : 1;
    localparam int RW = (FM_H > 2) ? $clog2(FM_H) : 1;
    localparam int LN = FM_W / 2;
    localparam int LW = (LN > 1) ? $clog2(LN) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(FM_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FM_H - 1);

    function automatic logic signed [DW-1:0] smax(
        input logic signed [DW-1:0] a,
        input logic signed [DW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Reset asserts immediately, releases two clocks after i_rst_n rises.
    logic [1:0] rst_sync;
    logic       rst_n_int;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n_int = rst_sync[1];

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic signed [DW-1:0] pair_q;
    logic signed [DW-1:0] linebuf [LN];

    logic                 accept;
    logic                 col_odd, row_odd, col_last, row_last;
    logic [LW-1:0]        lb_idx;
    logic signed [DW-1:0] hmax, vmax;

    assign accept   = i_valid && !i_flush;
    assign col_odd  = col[0];
    assign row_odd  = row[0];
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign lb_idx   = LW'(col >> 1);
    assign hmax     = smax(pair_q, i_data);
    assign vmax     = smax(hmax, linebuf[lb_idx]);

    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            col          <= '0;
            row          <= '0;
            pair_q       <= '0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
            o_data       <= '0;
        end else if (i_flush) begin
            // Partial window is abandoned: counters restart at (0,0); the
            // stale pair/line-buffer values are overwritten before use.
            col          <= '0;
            row          <= '0;
            o_valid      <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_valid      <= accept && row_odd && col_odd;
            o_frame_done <= accept && row_last && col_last;
            if (accept) begin
                if (!col_odd)           pair_q <= i_data;
                if (row_odd && col_odd) o_data <= vmax;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Line buffer carries no reset: every entry is rewritten on the even
    // row before the odd row reads it.
    always_ff @(posedge i_clk) begin
        if (accept && col_odd && !row_odd) linebuf[lb_idx] <= hmax;
    end

endmodule

// File: tb/tb_pool2x2_stream.sv
// tb_pool2x2_stream
//   Directed bench for pool2x2_stream at FM_W=FM_H=4, DW=16. Inputs are
//   driven 1 ns after the rising edge and outputs are sampled 1 ns after
//   the next rising edge, so each check sees the result of the sample just
//   applied (1-clock latency).

module tb_pool2x2_stream;

    localparam int DW = 16;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n = 1'b0;
    logic                 i_flush = 1'b0;
    logic                 i_valid = 1'b0;
    logic signed [DW-1:0] i_data = '0;
    logic                 o_valid;
    logic signed [DW-1:0] o_data;
    logic                 o_frame_done;

    int n_chk = 0;
    int n_err = 0;
    int last_out = 0;

    pool2x2_stream #(.DW(DW), .FM_W(4), .FM_H(4)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input int d, input logic f);
        i_valid = v;
        i_data  = DW'(d);
        i_flush = f;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 0, 1'b0);
            chk("idle_valid", int'(o_valid), 0);
        end
    endtask

    // Frame of samples i (+base), or -i when neg. Outputs land on raster
    // indices 5,7,13,15; the window max is the bottom-right sample for an
    // increasing ramp and the top-left sample (index i-5) when negated.
    task automatic run_frame(input string tag, input int base, input bit neg, input bit gaps);
        int  d, exp_d;
        bit  ov;
        for (int i = 0; i < 16; i++) begin
            d = neg ? -i : base + i;
            step(1'b1, d, 1'b0);
            ov = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            chk({tag, "_valid"}, int'(o_valid), int'(ov));
            chk({tag, "_done"}, int'(o_frame_done), int'(i == 15));
            if (ov) begin
                exp_d = neg ? -(i - 5) : base + i;
                chk({tag, "_data"}, int'(o_data), exp_d);
                last_out = exp_d;
            end
            if (gaps) begin
                step(1'b0, 777, 1'b0);
                chk({tag, "_gap_valid"}, int'(o_valid), 0);
                chk({tag, "_gap_done"}, int'(o_frame_done), 0);
                chk({tag, "_gap_hold"}, int'(o_data), last_out);
            end
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_done", int'(o_frame_done), 0);
        chk("rst_data", int'(o_data), 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        idle(3);

        run_frame("ramp", 0, 1'b0, 1'b0);
        run_frame("neg", 0, 1'b1, 1'b0);
        run_frame("gap", 0, 1'b0, 1'b1);

        // Partial frame, then asynchronous reset mid-frame
        for (int i = 0; i < 6; i++) step(1'b1, 50 + i, 1'b0);
        chk("pre_rst_data", int'(o_data), 55);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_rst_data", int'(o_data), 0);
        chk("async_rst_valid", int'(o_valid), 0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        last_out = 0;
        idle(3);
        run_frame("after_rst", 0, 1'b0, 1'b0);

        // Flush after 9 samples, flush cycle also carries i_valid
        for (int i = 0; i < 9; i++) step(1'b1, 200 + i, 1'b0);
        chk("pre_flush_data", int'(o_data), 207);
        step(1'b1, 999, 1'b1);
        chk("flush_valid", int'(o_valid), 0);
        chk("flush_done", int'(o_frame_done), 0);
        last_out = 207;
        run_frame("after_flush", 0, 1'b0, 1'b0);

        // Back-to-back frames
        run_frame("b2b0", 0, 1'b0, 1'b0);
        run_frame("b2b1", 100, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
